bounds_region_tracker: RTL

Parametrised successor to the single-rectangle bounds check. Holds a runtime-loadable table of NREG rectangles and tests a stream of (x, y) samples against all of them in a 2-stage pipeline. Produces a raw hit mask, the lowest-index hit, and debounced per-region "held" state with enter/exit pulses. Sits between the pointer/object-position logic and game/UI logic on the 65 MHz pixel-domain clock.

---
 rtl/bounds_region_tracker_if.sv | 35 +++
 rtl/bounds_region_tracker.sv | 132 +++++++++++++
 2 files changed

// File: rtl/bounds_region_tracker_if.sv
// bounds_region_tracker_if: table-write, sample and result signals of bounds_region_tracker.
interface bounds_region_tracker_if #(
    parameter int NREG  = 4,
    parameter int IDX_W = 2,
    parameter int XW    = 11,
    parameter int YW    = 10
);
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [XW-1:0]    cfg_left;
    logic [XW-1:0]    cfg_right;
    logic [YW-1:0]    cfg_top;
    logic [YW-1:0]    cfg_bottom;
    logic             cfg_en;
    logic             in_valid;
    logic [XW-1:0]    check_x;
    logic [YW-1:0]    check_y;
    logic             out_valid;
    logic [NREG-1:0]  hit_mask;
    logic             any_hit;
    logic [IDX_W-1:0] hit_idx;
    logic [NREG-1:0]  held_mask;
    logic [NREG-1:0]  enter_pulse;
    logic [NREG-1:0]  exit_pulse;
    modport master (
        output cfg_we, cfg_idx, cfg_left, cfg_right, cfg_top, cfg_bottom, cfg_en,
        output in_valid, check_x, check_y,
        input  out_valid, hit_mask, any_hit, hit_idx, held_mask, enter_pulse, exit_pulse
    );
    modport slave (
        input  cfg_we, cfg_idx, cfg_left, cfg_right, cfg_top, cfg_bottom, cfg_en,
        input  in_valid, check_x, check_y,
        output out_valid, hit_mask, any_hit, hit_idx, held_mask, enter_pulse, exit_pulse
    );
endinterface

// File: rtl/bounds_region_tracker.sv
// bounds_region_tracker: tests (x,y) samples against NREG loadable rectangles in a 2-stage pipeline.
// Define BOUNDS_DEBOUNCE_EN to build HOLD-sample debounce counters; otherwise held follows each hit.
module bounds_region_tracker #(
    parameter int NREG  = 4,
    parameter int IDX_W = 2,
    parameter int XW    = 11,
    parameter int YW    = 10,
    parameter int HOLD  = 8
) (
    input logic clk_i,
    input logic reset_i,
    bounds_region_tracker_if.slave bus
);
    if (HOLD < 1 || HOLD > 15 || NREG != (1 << IDX_W)) begin : g_bad_params
        $error("bounds_region_tracker: illegal HOLD/NREG/IDX_W");
    end

    logic [XW-1:0]    left_q   [NREG];
    logic [XW-1:0]    right_q  [NREG];
    logic [YW-1:0]    top_q    [NREG];
    logic [YW-1:0]    bottom_q [NREG];
    logic [NREG-1:0]  en_q, hit1_q, hit_mask_q, held_q, enter_q, exit_q;
    logic [NREG-1:0]  hit_d, wr_sel, held_d, enter_d, exit_d;
    logic             v1_q, out_valid_q, any_hit_q;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;

    always_comb begin
        hit_idx_d = '0;
        for (int i = 0; i < NREG; i++) begin
            hit_d[i]  = en_q[i] && bus.check_x >= left_q[i] && bus.check_x <= right_q[i]
                        && bus.check_y >= top_q[i] && bus.check_y <= bottom_q[i];
            wr_sel[i] = bus.cfg_we && bus.cfg_idx == IDX_W'(i);
        end
        for (int i = NREG - 1; i >= 0; i--)
            hit_idx_d = hit1_q[i] ? IDX_W'(i) : hit_idx_d;
    end

`ifdef BOUNDS_DEBOUNCE_EN
    logic [3:0] cnt_q [NREG];
    logic [3:0] cnt_d [NREG];
    logic [3:0] nxt   [NREG];

    // A table write to a region overrides any in-flight stage-2 update for it.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            nxt[i]     = cnt_q[i] + 4'd1;
            cnt_d[i]   = cnt_q[i];
            held_d[i]  = held_q[i];
            enter_d[i] = 1'b0;
            exit_d[i]  = 1'b0;
            if (wr_sel[i]) begin
                cnt_d[i]  = '0;
                held_d[i] = 1'b0;
            end else if (v1_q) begin
                if (hit1_q[i] == held_q[i]) begin
                    cnt_d[i] = '0;
                end else if (nxt[i] == 4'(HOLD)) begin
                    cnt_d[i]   = '0;
                    held_d[i]  = ~held_q[i];
                    enter_d[i] = hit1_q[i];
                    exit_d[i]  = ~hit1_q[i];
                end else begin
                    cnt_d[i] = nxt[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
        else
            for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
    end
`else
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            held_d[i]  = wr_sel[i] ? 1'b0 : v1_q ? hit1_q[i] : held_q[i];
            enter_d[i] = !wr_sel[i] && v1_q && hit1_q[i] && !held_q[i];
            exit_d[i]  = !wr_sel[i] && v1_q && !hit1_q[i] && held_q[i];
        end
    end
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NREG; i++) begin
                left_q[i]   <= '0;
                right_q[i]  <= '0;
                top_q[i]    <= '0;
                bottom_q[i] <= '0;
            end
            en_q        <= '0;
            v1_q        <= 1'b0;
            hit1_q      <= '0;
            out_valid_q <= 1'b0;
            hit_mask_q  <= '0;
            any_hit_q   <= 1'b0;
            hit_idx_q   <= '0;
            held_q      <= '0;
            enter_q     <= '0;
            exit_q      <= '0;
        end else begin
            if (bus.cfg_we) begin
                left_q[bus.cfg_idx]   <= bus.cfg_left;
                right_q[bus.cfg_idx]  <= bus.cfg_right;
                top_q[bus.cfg_idx]    <= bus.cfg_top;
                bottom_q[bus.cfg_idx] <= bus.cfg_bottom;
                en_q[bus.cfg_idx]     <= bus.cfg_en;
            end
            v1_q        <= bus.in_valid;
            hit1_q      <= hit_d;
            out_valid_q <= v1_q;
            if (v1_q) begin
                hit_mask_q <= hit1_q;
                any_hit_q  <= |hit1_q;
                hit_idx_q  <= hit_idx_d;
            end
            held_q  <= held_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.hit_mask    = hit_mask_q;
    assign bus.any_hit     = any_hit_q;
    assign bus.hit_idx     = hit_idx_q;
    assign bus.held_mask   = held_q;
    assign bus.enter_pulse = enter_q;
    assign bus.exit_pulse  = exit_q;
endmodule
